ps2_keypad: RTL and testbench

PS2_KEYPAD -- requirements
Module: ps2_keypad

---
 rtl/ps2_keypad.sv | 225 ++++++++++++++++++++++
 tb/tb_ps2_keypad.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keypad.sv
// PS/2 keyboard receiver that decodes scan-set-2 keys into a 4-bit keypad code (0-9, +, -, =, clear).
// Latency: new_data_o strobes SYNC_STAGES+1 clk_i cycles after the stop-bit falling edge on ps2_clk_i.
// Backpressure: none; results are one-cycle strobes that the consumer must take when they appear.
// Optional build macro PS2_PARITY_CHECK_EN: when defined, frames with even data+parity are rejected.
`timescale 1ns/1ps
module ps2_keypad #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned SYNC_STAGES    = 2      // legal range 2..4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [3:0] digit_o,
    output logic       new_data_o,
    output logic       frame_err_o
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Both PS/2 lines idle high, so the synchronizers and edge history reset to 1
    // to avoid a phantom falling edge right after reset release.
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;
    logic                   ps2_clk_s;
    logic                   ps2_dat_s;
    logic                   fall;

    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            brk_q, brk_d;
    logic            ext_q, ext_d;
    logic [3:0]      digit_q, digit_d;
    logic            new_data_q, new_data_d;
    logic            frame_err_q, frame_err_d;
    logic            frame_ok;
    logic [4:0]      key;
`ifdef PS2_PARITY_CHECK_EN
    logic            parity_q, parity_d;
`endif

    // Scan code to keypad code: bit 4 = recognised, bits 3:0 = code.
    // With the E0 prefix only the Enter keys ('=') are accepted.
    function automatic logic [4:0] map_key(input logic [7:0] code, input logic ext);
        logic [4:0] r;
        case (code)
            8'h45, 8'h70: r = {1'b1, 4'd0};
            8'h16, 8'h69: r = {1'b1, 4'd1};
            8'h1E, 8'h72: r = {1'b1, 4'd2};
            8'h26, 8'h7A: r = {1'b1, 4'd3};
            8'h25, 8'h6B: r = {1'b1, 4'd4};
            8'h2E, 8'h73: r = {1'b1, 4'd5};
            8'h36, 8'h74: r = {1'b1, 4'd6};
            8'h3D, 8'h6C: r = {1'b1, 4'd7};
            8'h3E, 8'h75: r = {1'b1, 4'd8};
            8'h46, 8'h7D: r = {1'b1, 4'd9};
            8'h79:        r = {1'b1, 4'd10};
            8'h4E, 8'h7B: r = {1'b1, 4'd11};
            8'h55, 8'h5A: r = {1'b1, 4'd12};
            8'h76:        r = {1'b1, 4'd13};
            default:      r = 5'd0;
        endcase
        if (ext && (code != 8'h55) && (code != 8'h5A)) begin
            r = 5'd0;
        end
        return r;
    endfunction

    assign ps2_clk_s = clk_sync_q[SYNC_STAGES-1];
    assign ps2_dat_s = dat_sync_q[SYNC_STAGES-1];
    assign fall      = clk_prev_q & ~ps2_clk_s;
    assign key       = map_key(shift_q, ext_q);

    // A frame is accepted when the stop bit just sampled is 1 (and parity is odd when checked).
`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = ps2_dat_s & (^{shift_q, parity_q});
`else
    assign frame_ok = ps2_dat_s;
`endif

    // Synchronize the asynchronous PS/2 lines and keep clock history for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            clk_prev_q <= ps2_clk_s;
        end
    end

    // Receive FSM state, datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            wd_cnt_q    <= '0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            digit_q     <= '0;
            new_data_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            wd_cnt_q    <= wd_cnt_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            digit_q     <= digit_d;
            new_data_q  <= new_data_d;
            frame_err_q <= frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q    <= parity_d;
`endif
        end
    end

    // Next-state logic: frame assembly, prefix handling, key decode and watchdog abort.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        wd_cnt_d    = wd_cnt_q;
        brk_d       = brk_q;
        ext_d       = ext_q;
        digit_d     = digit_q;
        new_data_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d    = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                wd_cnt_d = '0;
                // A high data bit on an edge here is line noise, not a start bit.
                if (fall && !ps2_dat_s) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            S_DATA: begin
                if (fall) begin
                    shift_d   = {ps2_dat_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_d = ps2_dat_s;
`endif
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    state_d = S_IDLE;
                    if (!frame_ok) begin
                        frame_err_d = 1'b1;
                    end else if (brk_q) begin
                        // Key release: swallow the code; an E0 here still prefixes it.
                        brk_d = 1'b0;
                        if (shift_q != 8'hE0) begin
                            ext_d = 1'b0;
                        end
                    end else if (shift_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else if (shift_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else begin
                        ext_d = 1'b0;
                        if (key[4]) begin
                            new_data_d = 1'b1;
                            digit_d    = key[3:0];
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Watchdog: any stalled partial frame is dropped so the next start bit resyncs.
        if (state_q != S_IDLE) begin
            if (fall) begin
                wd_cnt_d = '0;
            end else if (wd_cnt_q == WD_LAST) begin
                state_d     = S_IDLE;
                frame_err_d = 1'b1;
                wd_cnt_d    = '0;
                shift_d     = '0;
                bit_cnt_d   = '0;
            end else begin
                wd_cnt_d = wd_cnt_q + WD_W'(1);
            end
        end
    end

    assign digit_o     = digit_q;
    assign new_data_o  = new_data_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_ps2_keypad.sv
// Directed bench for ps2_keypad: 1 MHz clk_i, PS/2 clock at 12.5 kHz (40 clk_i cycles per half period).
// Latency checked: strobe 3 clk_i cycles after the stop-bit falling edge with 2 sync stages.
// Backpressure: none; a negedge monitor counts strobes and error pulses.
`timescale 1ns/1ps
module tb_ps2_keypad;

    localparam int TO   = 500;
    localparam int HALF = 40;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [3:0] digit;
    logic       nd;
    logic       fe;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int nd_cnt   = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;
    int nd_cyc   = 0;
    int edge_cyc = 0;
    logic [3:0] nd_digit = 4'd0;
    int n0;
    int f0;

    ps2_keypad #(
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .ps2_clk_i(ps2_clk),
        .ps2_data_i(ps2_dat),
        .digit_o(digit),
        .new_data_o(nd),
        .frame_err_o(fe)
    );

    always #500 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (nd) begin
            nd_cnt   = nd_cnt + 1;
            nd_cyc   = cyc;
            nd_digit = digit;
        end
        if (fe) fe_cnt = fe_cnt + 1;
        if (nd && fe) both_cnt = both_cnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic pflip, input logic stop);
        return {stop, (~^b) ^ pflip, b, 1'b0};
    endfunction

    // Send the first n bits of a frame, LSB (start bit) first; data changes while the clock is high.
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat = f[i];
            wait_clks(HALF);
            ps2_clk  = 1'b0;
            edge_cyc = cyc;
            wait_clks(HALF);
            ps2_clk  = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(frame(b, 1'b0, 1'b1), 11);
        wait_clks(HALF);
    endtask

    task automatic mark();
        n0 = nd_cnt;
        f0 = fe_cnt;
    endtask

    initial begin
        // Reset state
        wait_clks(5);
        check("rst_digit", int'(digit), 0);
        check("rst_new_data", int'(nd), 0);
        check("rst_frame_err", int'(fe), 0);
        rst_n = 1'b1;
        wait_clks(5);

        // Single frame 0x16 -> digit 1, with latency and hold checks
        mark();
        send_byte(8'h16);
        check("f16_strobes", nd_cnt - n0, 1);
        check("f16_digit", int'(nd_digit), 1);
        check("f16_errs", fe_cnt - f0, 0);
        check("f16_latency", nd_cyc - edge_cyc, 3);
        wait_clks(100);
        check("f16_hold", int'(digit), 1);

        // Make then break of '0'
        mark();
        send_byte(8'h45);
        send_byte(8'hF0);
        send_byte(8'h45);
        check("brk_strobes", nd_cnt - n0, 1);
        check("brk_digit", int'(digit), 0);

        // Extended Enter make then break
        mark();
        send_byte(8'hE0);
        send_byte(8'h5A);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h5A);
        check("ext_strobes", nd_cnt - n0, 1);
        check("ext_digit", int'(nd_digit), 12);
        check("ext_errs", fe_cnt - f0, 0);

        // 0x26 with flipped parity
        mark();
        send_bits(frame(8'h26, 1'b1, 1'b1), 11);
        wait_clks(HALF);
`ifdef PS2_PARITY_CHECK_EN
        check("par_strobes", nd_cnt - n0, 0);
        check("par_errs", fe_cnt - f0, 1);
        check("par_digit", int'(digit), 12);
`else
        check("par_strobes", nd_cnt - n0, 1);
        check("par_errs", fe_cnt - f0, 0);
        check("par_digit", int'(digit), 3);
`endif

        // Partial frame aborted by watchdog, then a full 0x76 frame
        mark();
        send_bits(frame(8'h76, 1'b0, 1'b1), 4);
        wait_clks(TO + 10);
        check("to_errs", fe_cnt - f0, 1);
        check("to_strobes", nd_cnt - n0, 0);
        send_byte(8'h76);
        check("to_after_strobes", nd_cnt - n0, 1);
        check("to_after_digit", int'(nd_digit), 13);
        check("to_after_errs", fe_cnt - f0, 1);

        // Reset after the 6th edge of 0x7B, then a full 0x7B frame
        mark();
        send_bits(frame(8'h7B, 1'b0, 1'b1), 6);
        rst_n = 1'b0;
        wait_clks(5);
        check("mid_rst_digit", int'(digit), 0);
        rst_n = 1'b1;
        wait_clks(2 * HALF);
        check("mid_rst_quiet", nd_cnt - n0, 0);
        send_byte(8'h7B);
        check("mid_rst_strobes", nd_cnt - n0, 1);
        check("mid_rst_digit_after", int'(nd_digit), 11);
        check("mid_rst_errs", fe_cnt - f0, 0);

        // Unmapped byte, then 0x79 with a bad stop bit
        mark();
        send_byte(8'h1C);
        send_bits(frame(8'h79, 1'b0, 1'b0), 11);
        wait_clks(HALF);
        check("stop_strobes", nd_cnt - n0, 0);
        check("stop_errs", fe_cnt - f0, 1);
        check("stop_digit", int'(digit), 11);

        // Typematic repeats of keypad '1'
        mark();
        send_byte(8'h69);
        send_byte(8'h69);
        send_byte(8'h69);
        check("rep_strobes", nd_cnt - n0, 3);
        check("rep_digit", int'(digit), 1);

        // E0-prefixed digit ignored; prefix does not leak into the next key
        mark();
        send_byte(8'hE0);
        send_byte(8'h16);
        check("extdig_strobes", nd_cnt - n0, 0);
        send_byte(8'h79);
        check("plus_strobes", nd_cnt - n0, 1);
        check("plus_digit", int'(nd_digit), 10);
        check("extdig_errs", fe_cnt - f0, 0);

        check("no_overlap", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
